// File: rtl/bp_pkg.sv
// Shared branch-predictor types: the resolved-branch update record fed to the BHT.
package bp_pkg;

   typedef logic [31:0] addr_t;

   typedef struct packed {
      addr_t pc;
      addr_t dest;
      logic  taken;
   } bp_update_t;

endpackage

// File: rtl/bp_update_fifo.sv
// Entry storage for bp_update_queue: DEPTH x bp_update_t, one write and one async read port.
// Pointers wrap naturally because DEPTH is a power of two; fullness is tracked by the owner.
module bp_update_fifo
   import bp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       wr_en,
   input  bp_update_t wr_data,
   input  logic       rd_en,
   output bp_update_t rd_data
);

   localparam int PW = $clog2(DEPTH);

   bp_update_t    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // NOTE: entry storage is deliberately not reset; stale entries are never visible
   // because the owner's count gates the head, and leaving it unreset allows LUTRAM.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/bp_update_queue.sv
// Decouples exe-stage branch resolutions from the BHT write port; never stalls exe,
// drops on overflow. Optional macro BP_UPDATE_BYPASS_EN adds an empty-queue bypass.
module bp_update_queue
   import bp_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int DROP_BITS = 8
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       in_valid,
   input  addr_t                      in_pc,
   input  addr_t                      in_dest,
   input  logic                       in_taken,
   output logic                       out_valid,
   output addr_t                      out_pc,
   output addr_t                      out_dest,
   output logic                       out_taken,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic [DROP_BITS-1:0]       drop_cnt
);

   localparam int CW = $clog2(DEPTH) + 1;

   bp_update_t head;
   bp_update_t in_upd;
   bp_update_t pres;
   logic       pres_valid;
   logic       empty;
   logic       full;
   logic       deq;
   logic       enq;
   logic       drop;
   logic       byp_hit;

   bp_update_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .wr_en   (enq),
      .wr_data (in_upd),
      .rd_en   (deq),
      .rd_data (head)
   );

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   // NOTE: every signal driven here gets a default first so no path can infer a latch.
   always_comb begin
      in_upd     = '{pc: in_pc, dest: in_dest, taken: in_taken};
      deq        = !empty && out_ready;
      byp_hit    = 1'b0;
      pres_valid = !empty;
      pres       = empty ? '0 : head;
`ifdef BP_UPDATE_BYPASS_EN
      // resetn gates the bypass so nothing reaches the BHT while in reset.
      if (empty && in_valid && resetn) begin
         pres_valid = 1'b1;
         pres       = in_upd;
         byp_hit    = out_ready;
      end
`endif
      // A dequeue in the same cycle frees the slot the incoming update needs.
      enq  = in_valid && !byp_hit && (!full || deq);
      drop = in_valid && full && !deq;
   end

   assign out_valid = pres_valid;
   assign out_pc    = pres.pc;
   assign out_dest  = pres.dest;
   assign out_taken = pres.taken;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count    <= '0;
         drop_cnt <= '0;
      end else begin
         case ({enq, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
      end
   end

endmodule

// File: doc/bp_update_queue.md
BP_UPDATE_QUEUE -- requirements
Module: bp_update_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered updates (power of two, at least 2).
REQ-002 SHALL have parameter DROP_BITS, default 8, width of the drop counter.
REQ-003 SHALL have port clk, input, 1, the single clock for all state.
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, exe stage has a resolved branch this cycle.
REQ-006 SHALL have port in_pc, input, addr_t (32), pc of the resolved branch.
REQ-007 SHALL have port in_dest, input, addr_t (32), resolved branch target.
REQ-008 SHALL have port in_taken, input, 1, resolved direction.
REQ-009 SHALL have port out_valid, input-side name is_write, output, 1, update presented to the BHT write port.
REQ-010 SHALL have port out_pc, output, addr_t, drives the BHT executed_branch_pc.
REQ-011 SHALL have port out_dest, output, addr_t, drives the BHT dest_pc.
REQ-012 SHALL have port out_taken, output, 1, drives the BHT is_taken.
REQ-013 SHALL have port out_ready, input, 1, BHT accepts the presented update this cycle (tied high when the BHT never stalls).
REQ-014 SHALL have port count, output, $clog2(DEPTH)+1, current occupancy.
REQ-015 SHALL have port drop_cnt, output, DROP_BITS, saturating count of discarded updates.

Function
REQ-016 SHALL keep the queue strictly FIFO; the head entry drives out_pc/out_dest/out_taken and out_valid = (count != 0).
REQ-017 SHALL dequeue on (out_valid and out_ready) at the clock edge; out_* SHALL hold stable while out_valid and not out_ready.
REQ-018 SHALL make an update enqueued at edge t visible on out_* in cycle t+1 (one-cycle latency, no combinational in->out path unless REQ-031).
REQ-019 SHALL never stall exe: in_valid has no ready; when full and no dequeue occurs this cycle, the incoming update SHALL be discarded and drop_cnt incremented.
REQ-020 SHALL accept the incoming update when full if a dequeue occurs in the same cycle (no drop, count unchanged).
REQ-021 SHALL apply simultaneous enqueue and dequeue when not empty with count unchanged and both pointers advancing.
REQ-022 SHALL wrap read/write pointers modulo DEPTH; full/empty SHALL be derived from count, not pointer equality.
REQ-023 SHALL saturate drop_cnt at all-ones; it never wraps.
REQ-024 SHALL drive out_pc/out_dest/out_taken to 0 when out_valid is 0.

Reset
REQ-025 SHALL, on resetn low, asynchronously clear count, pointers and drop_cnt to 0, forcing out_valid=0 and out_* to 0.
REQ-026 SHALL discard all queued entries on reset mid-operation; entry storage needs no reset.
REQ-027 SHALL ignore in_valid while resetn is low and in the first edge after release only if resetn is low at that edge.
REQ-028 SHALL not depend on the BHT's own sweep-clear; out_valid stays 0 while resetn is low.

Configuration
REQ-029 SHALL use macro BP_UPDATE_BYPASS_EN.
REQ-030 SHALL, without the macro, behave exactly as REQ-016..REQ-024.
REQ-031 SHALL, with the macro, when count==0 and in_valid, present in_* on out_* combinationally with out_valid=1; if out_ready the update is consumed and not enqueued, else it is enqueued normally.

Structure
REQ-032 SHALL place typedef bp_update_t (pc, dest, taken) in shared package bp_pkg; addr_t comes from common.svh.
REQ-033 SHALL implement storage in sub-module bp_update_fifo (DEPTH x bp_update_t, registers/LUTRAM, single write and read port); bp_update_queue holds count, drop logic and bypass.

Verification
REQ-034 SHALL cover: reset, then in_valid one cycle with pc=0xBFC00100, dest=0xBFC00200, taken=1 -> next cycle out_valid=1 with those values; with out_ready=1 count returns to 0 after one cycle.
REQ-035 SHALL cover: out_ready=0, five consecutive updates, DEPTH=4 -> count=4, drop_cnt=1, out_pc equals first pc throughout.
REQ-036 SHALL cover: full queue, out_ready=1 and in_valid same cycle -> count stays 4, drop_cnt unchanged, head advances by one.
REQ-037 SHALL cover: 10 enqueue/dequeue cycles across pointer wrap -> outputs in exact insertion order, no loss.
REQ-038 SHALL cover: DROP_BITS=2, 6 drops -> drop_cnt stops at 3; resetn pulsed low mid-stream with count=3 -> count=0, out_valid=0 immediately, drop_cnt=0.
REQ-039 SHALL cover with BP_UPDATE_BYPASS_EN: empty queue, in_valid with pc=0x80000010, out_ready=1 -> out_valid=1 same cycle, count stays 0.
